// File: rtl/system_consts.sv
// rtl/system_consts.sv - shared types and port indices for the DDR arbiter
package system_consts;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } ddr_arb_state_t;

  localparam logic DDR_ARB_PORT_A = 1'b0;
  localparam logic DDR_ARB_PORT_B = 1'b1;

endpackage

// File: rtl/ddr_if.sv
// rtl/ddr_if.sv - burst DDR port bundle shared by requesters and the downstream controller
interface ddr_if #(
  parameter int BURST_W = 8
) ();

  logic [31:0]        addr;
  logic [63:0]        wdata;
  logic [63:0]        rdata;
  logic               read;
  logic               write;
  logic [BURST_W-1:0] burstcnt;
  logic [7:0]         byteenable;
  logic               busy;
  logic               rdata_ready;

  modport master (
    output addr, wdata, read, write, burstcnt, byteenable,
    input  rdata, busy, rdata_ready
  );

  modport slave (
    input  addr, wdata, read, write, burstcnt, byteenable,
    output rdata, busy, rdata_ready
  );

endinterface

// File: rtl/ddr_arb_pick.sv
// rtl/ddr_arb_pick.sv - request-to-one-hot grant selector; DDR_ARB_ROUND_ROBIN_EN selects round robin
module ddr_arb_pick
  import system_consts::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

`ifdef DDR_ARB_ROUND_ROBIN_EN
  // ptr_i is the last owner; on a tie the other port goes first
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_i == DDR_ARB_PORT_A) ? 2'b10 : 2'b01;
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ptr_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[DDR_ARB_PORT_A]) begin
      gnt_o = 2'b01;
    end else if (req_i[DDR_ARB_PORT_B]) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ddr_arbiter.sv
// rtl/ddr_arbiter.sv - two-port burst-locked DDR arbiter; DDR_ARB_ROUND_ROBIN_EN enables round robin
module ddr_arbiter
  import system_consts::*;
#(
  parameter int BURST_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  ddr_if.slave       a,
  ddr_if.slave       b,
  ddr_if.master      x,
  output logic [1:0] grant
);

  ddr_arb_state_t     state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               rd_acc_q, rd_acc_d;
  logic [1:0]         req;
  logic [1:0]         pick;
  logic               ptr;
  logic               sel_b, a_own, b_own;
  logic               own_read, own_write, beat;
  logic [BURST_W-1:0] new_len;
  logic [BURST_W:0]   cnt_inc;

  assign req = {b.read | b.write, a.read | a.write};

  ddr_arb_pick u_pick (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (pick)
  );

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick != 2'b00) begin
      ptr_d = pick[DDR_ARB_PORT_B];
    end
  end

  // Reset to "B owned last" so the first tie goes to A
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= DDR_ARB_PORT_B;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = DDR_ARB_PORT_B;
`endif

  assign sel_b = grant_q[DDR_ARB_PORT_B];
  assign a_own = (state_q != IDLE) && grant_q[DDR_ARB_PORT_A];
  assign b_own = (state_q != IDLE) && grant_q[DDR_ARB_PORT_B];

  assign x.addr       = sel_b ? b.addr       : a.addr;
  assign x.wdata      = sel_b ? b.wdata      : a.wdata;
  assign x.burstcnt   = sel_b ? b.burstcnt   : a.burstcnt;
  assign x.byteenable = sel_b ? b.byteenable : a.byteenable;
  assign own_read     = sel_b ? b.read       : a.read;
  assign own_write    = sel_b ? b.write      : a.write;

  // Only one read command per burst reaches the controller
  assign x.read  = (state_q == RD) && own_read && !rd_acc_q;
  assign x.write = (state_q == WR) && own_write;

  assign a.busy        = a_own ? x.busy : 1'b1;
  assign b.busy        = b_own ? x.busy : 1'b1;
  assign a.rdata_ready = a_own && x.rdata_ready;
  assign b.rdata_ready = b_own && x.rdata_ready;
  assign a.rdata       = x.rdata;
  assign b.rdata       = x.rdata;

  assign beat    = (state_q == RD) ? x.rdata_ready : (x.write && !x.busy);
  assign cnt_inc = {1'b0, cnt_q} + {{BURST_W{1'b0}}, 1'b1};
  assign new_len = pick[DDR_ARB_PORT_B] ? b.burstcnt : a.burstcnt;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rd_acc_d = rd_acc_q;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          grant_d  = pick;
          cnt_d    = '0;
          rd_acc_d = 1'b0;
          len_d    = (new_len == '0) ? {{(BURST_W-1){1'b0}}, 1'b1} : new_len;
          state_d  = (pick[DDR_ARB_PORT_B] ? b.read : a.read) ? RD : WR;
        end
      end
      RD, WR: begin
        if (x.read && !x.busy) begin
          rd_acc_d = 1'b1;
        end
        // Compare one bit wider so a full-length burst ends without wrapping
        if (beat) begin
          cnt_d = cnt_inc[BURST_W-1:0];
          if (cnt_inc == {1'b0, len_q}) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      cnt_q    <= '0;
      len_q    <= '0;
      rd_acc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rd_acc_q <= rd_acc_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// tb/tb_ddr_arbiter.sv - randomized bench with behavioural arbiter model and directed scenarios
module tb_ddr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ddr_if #(.BURST_W(8)) a_if ();
  ddr_if #(.BURST_W(8)) b_if ();
  ddr_if #(.BURST_W(8)) x_if ();
  logic [1:0] grant;

  ddr_arbiter #(.BURST_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a_if),
    .b     (b_if),
    .x     (x_if),
    .grant (grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        rd;
    logic        both;
    logic [7:0]  bc;
    logic [31:0] addr;
  } job_t;

  job_t jq_a[$];
  job_t jq_b[$];

  task automatic push_job(input int p, input logic rd, input logic both,
                          input logic [7:0] bc, input logic [31:0] addr);
    job_t j;
    j.rd = rd; j.both = both; j.bc = bc; j.addr = addr;
    if (p == 0) jq_a.push_back(j);
    else        jq_b.push_back(j);
  endtask

  // requester and controller driver state
  logic        rd_v[2], wr_v[2];
  logic [31:0] ad_v[2];
  logic [7:0]  bc_v[2], be_v[2];
  logic [63:0] wd_v[2];
  int          mode[2], rem[2];
  bit          s_acc[2], s_rr[2];
  bit          s_rst, s_xacc;
  logic [7:0]  s_xbc;
  int          pend = 0;
  int          ddr_mode = 1;
  bit          ddr_stall = 0;
  bit          rand_gap = 0;
  bit          chk_en = 0;

  initial begin
    for (int p = 0; p < 2; p++) begin
      rd_v[p] = 0; wr_v[p] = 0; ad_v[p] = 0; bc_v[p] = 0; be_v[p] = 0; wd_v[p] = 0;
      mode[p] = 0; rem[p] = 0;
    end
    a_if.read = 0; a_if.write = 0; a_if.addr = 0; a_if.burstcnt = 0; a_if.byteenable = 0; a_if.wdata = 0;
    b_if.read = 0; b_if.write = 0; b_if.addr = 0; b_if.burstcnt = 0; b_if.byteenable = 0; b_if.wdata = 0;
    x_if.busy = 0; x_if.rdata_ready = 0; x_if.rdata = 0;
    forever begin
      @(negedge clk);
      s_rst    = reset;
      s_acc[0] = (a_if.read | a_if.write) & ~a_if.busy;
      s_acc[1] = (b_if.read | b_if.write) & ~b_if.busy;
      s_rr[0]  = a_if.rdata_ready;
      s_rr[1]  = b_if.rdata_ready;
      s_xacc   = x_if.read & ~x_if.busy;
      s_xbc    = x_if.burstcnt;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (s_rst) begin
          mode[p] = 0; rd_v[p] = 0; wr_v[p] = 0;
        end else begin
          case (mode[p])
            0: begin
              if ((p == 0 ? jq_a.size() : jq_b.size()) > 0 &&
                  (!rand_gap || $urandom_range(0, 3) == 0)) begin
                job_t j;
                if (p == 0) j = jq_a.pop_front();
                else        j = jq_b.pop_front();
                ad_v[p] = j.addr; bc_v[p] = j.bc;
                be_v[p] = 8'($urandom); wd_v[p] = {$urandom, $urandom};
                rem[p]  = (j.bc == 0) ? 1 : int'(j.bc);
                if (j.rd) begin
                  rd_v[p] = 1; wr_v[p] = j.both; mode[p] = 1;
                end else begin
                  wr_v[p] = 1; mode[p] = 3;
                end
              end
            end
            1: if (s_acc[p]) begin
              rd_v[p] = 0; wr_v[p] = 0; mode[p] = 2;
            end
            2: if (s_rr[p]) begin
              rem[p]--;
              if (rem[p] == 0) mode[p] = 0;
            end
            3: if (s_acc[p]) begin
              rem[p]--;
              wd_v[p] = {$urandom, $urandom};
              if (rem[p] == 0) begin
                wr_v[p] = 0; mode[p] = 0;
              end
            end
            default: mode[p] = 0;
          endcase
        end
      end
      if (s_xacc) pend += (s_xbc == 0) ? 1 : int'(s_xbc);
      x_if.rdata_ready = 0;
      if (pend > 0 && !ddr_stall && (ddr_mode != 0 || $urandom_range(0, 2) != 0)) begin
        x_if.rdata_ready = 1;
        pend--;
      end
      x_if.rdata = {$urandom, $urandom};
      if (ddr_mode == 0)      x_if.busy = ($urandom_range(0, 2) == 0);
      else if (ddr_mode == 1) x_if.busy = 0;
      else                    x_if.busy = ~x_if.busy;
      a_if.read = rd_v[0]; a_if.write = wr_v[0]; a_if.addr = ad_v[0];
      a_if.burstcnt = bc_v[0]; a_if.byteenable = be_v[0]; a_if.wdata = wd_v[0];
      b_if.read = rd_v[1]; b_if.write = wr_v[1]; b_if.addr = ad_v[1];
      b_if.burstcnt = bc_v[1]; b_if.byteenable = be_v[1]; b_if.wdata = wd_v[1];
    end
  end

  // Behavioural model: owner (0 none, 1 A, 2 B), burst kind, beats still owed
  int m_own = 0;
  int m_last = 2;
  int m_rem = 0;
  bit m_rd = 0;
  bit m_sent = 0;

  function automatic bit own_rd_in();
    return (m_own == 1) ? a_if.read : b_if.read;
  endfunction

  function automatic bit own_wr_in();
    return (m_own == 1) ? a_if.write : b_if.write;
  endfunction

  function automatic bit exp_xread();
    return (m_own != 0) && m_rd && own_rd_in() && !m_sent;
  endfunction

  function automatic bit exp_xwrite();
    return (m_own != 0) && !m_rd && own_wr_in();
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_own = 0; m_last = 2; m_sent = 0;
    end else if (m_own == 0) begin
      bit ra, rb;
      int c;
      logic [7:0] bcv;
      ra = a_if.read | a_if.write;
      rb = b_if.read | b_if.write;
      c = 0;
      if (ra && rb) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
        c = (m_last == 1) ? 2 : 1;
`else
        c = 1;
`endif
      end else if (ra) c = 1;
      else if (rb) c = 2;
      if (c != 0) begin
        m_own  = c;
        m_last = c;
        m_rd   = (c == 1) ? a_if.read : b_if.read;
        bcv    = (c == 1) ? a_if.burstcnt : b_if.burstcnt;
        m_rem  = (bcv == 0) ? 1 : int'(bcv);
        m_sent = 0;
      end
    end else begin
      bit xr, xw, bt;
      xr = exp_xread();
      xw = exp_xwrite();
      bt = m_rd ? x_if.rdata_ready : (xw && !x_if.busy);
      if (xr && !x_if.busy) m_sent = 1;
      if (bt) begin
        m_rem--;
        if (m_rem == 0) m_own = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", grant, (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00);
      check("x_read", x_if.read, exp_xread());
      check("x_write", x_if.write, exp_xwrite());
      check("a_busy", a_if.busy, (m_own == 1) ? x_if.busy : 1'b1);
      check("b_busy", b_if.busy, (m_own == 2) ? x_if.busy : 1'b1);
      check("a_rdata_ready", a_if.rdata_ready, (m_own == 1) && x_if.rdata_ready);
      check("b_rdata_ready", b_if.rdata_ready, (m_own == 2) && x_if.rdata_ready);
      if (a_if.rdata_ready) check("a_rdata", a_if.rdata, x_if.rdata);
      if (b_if.rdata_ready) check("b_rdata", b_if.rdata, x_if.rdata);
      if (m_own != 0) begin
        check("x_addr", x_if.addr, (m_own == 1) ? a_if.addr : b_if.addr);
        check("x_wdata", x_if.wdata, (m_own == 1) ? a_if.wdata : b_if.wdata);
        check("x_burstcnt", x_if.burstcnt, (m_own == 1) ? a_if.burstcnt : b_if.burstcnt);
        check("x_byteenable", x_if.byteenable, (m_own == 1) ? a_if.byteenable : b_if.byteenable);
      end
    end
  end

  // Event counters for the directed scenarios
  int a_beats = 0, b_beats = 0, xw_beats = 0, a_busy_low = 0;
  logic [1:0] glog[$];

  always @(negedge clk) begin
    if (a_if.rdata_ready) a_beats++;
    if (b_if.rdata_ready) b_beats++;
    if (grant == 2'b10 && x_if.write && !x_if.busy) xw_beats++;
    if (grant == 2'b10 && !a_if.busy) a_busy_low++;
    glog.push_back(grant);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    a_beats = 0; b_beats = 0; xw_beats = 0; a_busy_low = 0;
    glog.delete();
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    tick();
    while (!(mode[0] == 0 && mode[1] == 0 && jq_a.size() == 0 && jq_b.size() == 0 &&
             m_own == 0 && pend == 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: waited %0d cycles, limit %0d", name, n, budget);
    end
  endtask

  // Owners in grant order and idle cycles before each
  logic [1:0] seq[$];
  int gaps[$];

  task automatic compress_log();
    int z;
    logic [1:0] prev;
    seq.delete();
    gaps.delete();
    z = 0;
    prev = 2'b00;
    foreach (glog[i]) begin
      if (glog[i] == 2'b00) z++;
      else if (glog[i] != prev) begin
        seq.push_back(glog[i]);
        gaps.push_back(z);
      end
      if (glog[i] != 2'b00) z = 0;
      prev = glog[i];
    end
    while (seq.size() < 3) begin
      seq.push_back(2'b00);
      gaps.push_back(-1);
    end
  endtask

  task automatic wait_beats(input int port, input int target, input int budget);
    int n;
    n = 0;
    while (((port == 0) ? a_beats : b_beats) < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", grant, 2'b00);
    check("reset_x_read", x_if.read, 1'b0);
    check("reset_x_write", x_if.write, 1'b0);
    check("reset_a_busy", a_if.busy, 1'b1);
    check("reset_b_busy", b_if.busy, 1'b1);
    chk_en = 1;
    reset = 0;
    tick();

    // A read of 4 beats while B is idle
    ddr_mode = 1;
    clear_mon();
    push_job(0, 1, 0, 8'd4, 32'h3000_0000);
    tick();
    check("t1_req_grant", grant, 2'b00);
    check("t1_req_busy", a_if.busy, 1'b1);
    tick();
    check("t1_grant", grant, 2'b01);
    check("t1_addr", x_if.addr, 32'h3000_0000);
    wait_beats(0, 4, 50);
    tick();
    check("t1_idle_after_last", grant, 2'b00);
    wait_quiet("t1", 100);
    check("t1_a_beats", a_beats, 4);
    check("t1_b_beats", b_beats, 0);

    // Simultaneous A write 2 and B read 8
    clear_mon();
    push_job(0, 0, 0, 8'd2, 32'h0000_1000);
    push_job(1, 1, 0, 8'd8, 32'h0000_2000);
    wait_quiet("t2", 200);
    compress_log();
`ifdef DDR_ARB_ROUND_ROBIN_EN
    check("t2_first", seq[0], 2'b10);
    check("t2_second", seq[1], 2'b01);
`else
    check("t2_first", seq[0], 2'b01);
    check("t2_second", seq[1], 2'b10);
`endif
    check("t2_bubble", gaps[1], 1);
    check("t2_b_beats", b_beats, 8);

    // B write 3 while the controller toggles busy
    ddr_mode = 2;
    clear_mon();
    push_job(1, 0, 0, 8'd3, 32'h0000_3000);
    tick();
    tick();
    push_job(0, 1, 0, 8'd1, 32'h0000_4000);
    wait_quiet("t3", 200);
    compress_log();
    check("t3_first", seq[0], 2'b10);
    check("t3_write_beats", xw_beats, 3);
    check("t3_a_held_busy", a_busy_low, 0);

    // burstcnt 0 behaves as one beat
    ddr_mode = 1;
    clear_mon();
    push_job(0, 1, 0, 8'd0, 32'h0000_5000);
    wait_beats(0, 1, 50);
    tick();
    check("t4_idle_after_single", grant, 2'b00);
    wait_quiet("t4", 100);
    check("t4_a_beats", a_beats, 1);

    // Reset after beat 2 of an 8-beat B read
    clear_mon();
    push_job(1, 1, 0, 8'd8, 32'h0000_6000);
    wait_beats(1, 2, 50);
    ddr_stall = 1;
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    ddr_stall = 0;
    tick();
    check("t5_grant_after_reset", grant, 2'b00);
    wait_quiet("t5_drain", 100);
    check("t5_b_beats", b_beats, 2);
    check("t5_a_beats", a_beats, 0);
    clear_mon();
    push_job(0, 1, 0, 8'd2, 32'h0000_7000);
    wait_quiet("t5_after", 100);
    compress_log();
    check("t5_regrant", seq[0], 2'b01);
    check("t5_a_after", a_beats, 2);

    // Back-to-back 255-beat B reads with A waiting in between
    clear_mon();
    push_job(1, 1, 0, 8'd255, 32'h0000_8000);
    push_job(1, 1, 0, 8'd255, 32'h0000_9000);
    tick();
    tick();
    push_job(0, 1, 0, 8'd4, 32'h0000_A000);
    wait_quiet("t6", 2000);
    compress_log();
    check("t6_first", seq[0], 2'b10);
    check("t6_between", seq[1], 2'b01);
    check("t6_third", seq[2], 2'b10);
    check("t6_b_beats", b_beats, 510);
    check("t6_a_beats", a_beats, 4);

    // Randomized traffic on both ports
    ddr_mode = 0;
    rand_gap = 1;
    for (int i = 0; i < 250; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic rd;
        logic [7:0] bc;
        rd = 1'($urandom_range(0, 1));
        bc = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 9));
        push_job(p, rd, rd && ($urandom_range(0, 7) == 0), bc, $urandom);
      end
    end
    wait_quiet("random", 60000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
